// File: rtl/scoreboard_pkg.sv
// Shared constants and FSM encoding for the result-text buffer (writer and overlay).
// Build with RESULT_TEXT_WRITER_CLEAR_EN to add the whole-buffer CLEAR state.
package scoreboard_pkg;

  localparam int X_BITS  = 9;
  localparam int Y_BITS  = 6;
  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;
  localparam int SCALE   = 2;

  localparam logic [1:0] PIX_FG = 2'b10;
  localparam logic [1:0] PIX_BG = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHAR_REQ,
    ST_CHAR_WAIT,
    ST_LINE_REQ,
    ST_LINE_WAIT,
    ST_WRITE,
    ST_DONE
`ifdef RESULT_TEXT_WRITER_CLEAR_EN
    , ST_CLEAR
`endif
  } state_t;

endpackage

// File: rtl/result_text_writer_if.sv
// Control, ROM-lookup and buffer-write signals of the result-text writer.
interface result_text_writer_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [4:0]  char_idx;
  logic [6:0]  char_code;
  logic [10:0] font_addr;
  logic [7:0]  font_line;
  logic [14:0] wr_addr;
  logic [1:0]  wr_data;
  logic        wr_en;

  modport master (
    input  start, char_code, font_line,
    output busy, done, char_idx, font_addr, wr_addr, wr_data, wr_en
  );

  modport slave (
    output start, char_code, font_line,
    input  busy, done, char_idx, font_addr, wr_addr, wr_data, wr_en
  );
endinterface

// File: rtl/result_text_writer_glyph_line_serializer.sv
// Picks the glyph bit for output column k of a x2-scaled cell and maps it to a pixel code.
module glyph_line_serializer
  import scoreboard_pkg::*;
(
  input  logic [GLYPH_W-1:0] i_line,
  input  logic [3:0]         i_k,
  output logic [1:0]         o_pix
);

  logic [2:0] w_bit_idx;

  // Two adjacent output columns share one glyph bit; bit 7 is the leftmost.
  assign w_bit_idx = 3'(GLYPH_W - 1 - int'(i_k) / SCALE);
  assign o_pix     = i_line[w_bit_idx] ? PIX_FG : PIX_BG;

endmodule

// File: rtl/result_text_writer.sv
// Renders a text string as x2-scaled 8x16 glyphs into the 2-bpp result-text buffer.
// Optional RESULT_TEXT_WRITER_CLEAR_EN: clear the whole buffer before each render.
module result_text_writer
  import scoreboard_pkg::*;
#(
  parameter int NUM_CHARS  = 32,
  parameter int ROW_OFFSET = 0
) (
  input logic               clk,
  input logic               rst,
  result_text_writer_if.master tw
);

  localparam int                ROW_W  = $clog2(GLYPH_H * SCALE);
  localparam logic [4:0]        LAST_C = 5'(NUM_CHARS - 1);
  localparam logic [Y_BITS-1:0] Y_OFF  = Y_BITS'(ROW_OFFSET);

  state_t               r_state, w_state_nxt;
  logic [4:0]           r_c;
  logic [ROW_W-1:0]     r_row;
  logic [3:0]           r_k;
  logic [6:0]           r_code;
  logic [GLYPH_W-1:0]   r_line;
  logic [14:0]          r_wr_addr;
  logic [1:0]           r_wr_data;
  logic                 r_wr_en;
  logic                 r_done;
`ifdef RESULT_TEXT_WRITER_CLEAR_EN
  logic [14:0]          r_clr_addr;
`endif

  logic [X_BITS-1:0]    w_x;
  logic [Y_BITS-1:0]    w_y;
  logic [1:0]           w_pix;

  assign w_x = {r_c, r_k};
  assign w_y = Y_OFF + Y_BITS'(r_row);

  glyph_line_serializer u_ser (
    .i_line (r_line),
    .i_k    (r_k),
    .o_pix  (w_pix)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (tw.start) begin
`ifdef RESULT_TEXT_WRITER_CLEAR_EN
          w_state_nxt = ST_CLEAR;
`else
          w_state_nxt = ST_CHAR_REQ;
`endif
        end
      end
      ST_CHAR_REQ:  w_state_nxt = ST_CHAR_WAIT;
      ST_CHAR_WAIT: w_state_nxt = ST_LINE_REQ;
      ST_LINE_REQ:  w_state_nxt = ST_LINE_WAIT;
      ST_LINE_WAIT: w_state_nxt = ST_WRITE;
      ST_WRITE: begin
        if (r_k == 4'hF) begin
          if (r_row != '1)       w_state_nxt = ST_LINE_REQ;
          else if (r_c != LAST_C) w_state_nxt = ST_CHAR_REQ;
          else                    w_state_nxt = ST_DONE;
        end
      end
      ST_DONE:      w_state_nxt = ST_IDLE;
`ifdef RESULT_TEXT_WRITER_CLEAR_EN
      ST_CLEAR:     if (r_clr_addr == '1) w_state_nxt = ST_CHAR_REQ;
`endif
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Write port is registered: a WRITE/CLEAR cycle shows up on wr_* one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_c       <= '0;
      r_row     <= '0;
      r_k       <= '0;
      r_code    <= '0;
      r_line    <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_en   <= 1'b0;
      r_done    <= 1'b0;
`ifdef RESULT_TEXT_WRITER_CLEAR_EN
      r_clr_addr <= '0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= (r_state == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (tw.start) begin
            r_c <= '0;
`ifdef RESULT_TEXT_WRITER_CLEAR_EN
            r_clr_addr <= '0;
`endif
          end
        end
        ST_CHAR_WAIT: begin
          r_code <= tw.char_code;
          r_row  <= '0;
        end
        ST_LINE_WAIT: begin
          r_line <= tw.font_line;
          r_k    <= '0;
        end
        ST_WRITE: begin
          r_wr_addr <= {w_y, w_x};
          r_wr_data <= w_pix;
          r_wr_en   <= 1'b1;
          r_k       <= r_k + 4'd1;
          if (r_k == 4'hF) begin
            if (r_row != '1)        r_row <= r_row + 1'b1;
            else if (r_c != LAST_C) r_c   <= r_c + 5'd1;
          end
        end
`ifdef RESULT_TEXT_WRITER_CLEAR_EN
        ST_CLEAR: begin
          r_wr_addr  <= r_clr_addr;
          r_wr_data  <= PIX_BG;
          r_wr_en    <= 1'b1;
          r_clr_addr <= r_clr_addr + 15'd1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign tw.char_idx  = r_c;
  assign tw.font_addr = {r_code, r_row[ROW_W-1:1]};
  assign tw.wr_addr   = r_wr_addr;
  assign tw.wr_data   = r_wr_data;
  assign tw.wr_en     = r_wr_en;
  assign tw.done      = r_done;
  // done trails the DONE state by a cycle, so busy is stretched to cover it.
  assign tw.busy      = (r_state != ST_IDLE) || r_done;

endmodule

// File: tb/tb_result_text_writer.sv
// Directed bench for result_text_writer: two-character text, ROM models, shadow buffer.
module tb_result_text_writer;

`ifdef RESULT_TEXT_WRITER_CLEAR_EN
  localparam int CLR_N = 32768;
  localparam logic [1:0] UNTOUCHED = 2'b00;
`else
  localparam int CLR_N = 0;
  localparam logic [1:0] UNTOUCHED = 2'b11;
`endif
  localparam int BUDGET = 1300 + CLR_N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  result_text_writer_if tw();

  result_text_writer #(.NUM_CHARS(2), .ROW_OFFSET(0)) dut (
    .clk (clk),
    .rst (rst),
    .tw  (tw)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int font_mode = 0;
  int sc;
  int wn, dcount, clr_bad, last_wr_cyc, done_cyc;
  bit log_clr = 1'b0;
  logic [1:0]  mem    [0:32767];
  logic [14:0] log_addr [0:2047];
  logic [10:0] log_fa   [0:2047];

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous text and font ROMs: data one cycle after the address.
  always @(posedge clk) begin
    tw.char_code <= (tw.char_idx == 5'd0) ? 7'h41 : (tw.char_idx == 5'd1) ? 7'h42 : 7'h00;
    if (font_mode == 0) tw.font_line <= 8'h81;
    else                tw.font_line <= (tw.font_addr[3:0] == 4'd0) ? 8'hFF : 8'h00;
  end

  always @(negedge clk) begin
    if (log_clr) begin
      wn <= 0; dcount <= 0; clr_bad <= 0; last_wr_cyc <= 0; done_cyc <= 0;
      for (int i = 0; i < 32768; i++) mem[i] <= 2'b11;
    end else begin
      if (tw.wr_en) begin
        if (wn < CLR_N) begin
          if (tw.wr_addr != wn[14:0] || tw.wr_data != 2'b00) clr_bad <= clr_bad + 1;
        end else if (wn - CLR_N < 2048) begin
          log_addr[wn - CLR_N] <= tw.wr_addr;
          log_fa[wn - CLR_N]   <= tw.font_addr;
        end
        mem[tw.wr_addr] <= tw.wr_data;
        wn <= wn + 1;
        last_wr_cyc <= cyc;
      end
      if (tw.done) begin
        dcount   <= dcount + 1;
        done_cyc <= cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic reset_logs();
    log_clr = 1'b1;
    step();
    log_clr = 1'b0;
  endtask

  task automatic start_pass(output int s);
    tw.start = 1'b1;
    step();
    tw.start = 1'b0;
    s = cyc;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (dcount == 0 && n < BUDGET) begin
      step();
      n++;
    end
    chk(tag, dcount, 1);
  endtask

  // Mismatches against the 0x81 glyph pattern over the two 16x32 cells.
  function automatic int pat81_bad();
    int bad = 0;
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++) begin
        int m = x % 16;
        logic [1:0] e = (m <= 1 || m >= 14) ? 2'b10 : 2'b00;
        if (mem[y * 512 + x] !== e) bad++;
      end
    return bad;
  endfunction

  function automatic int rows_bad(input int y0, input int y1, input logic [1:0] e);
    int bad = 0;
    for (int y = y0; y <= y1; y++)
      for (int x = 0; x < 32; x++)
        if (mem[y * 512 + x] !== e) bad++;
    return bad;
  endfunction

  initial begin
    tw.start = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    chk("rst_busy",      tw.busy, 0);
    chk("rst_done",      tw.done, 0);
    chk("rst_wr_en",     tw.wr_en, 0);
    chk("rst_wr_addr",   tw.wr_addr, 0);
    chk("rst_char_idx",  tw.char_idx, 0);
    chk("rst_font_addr", tw.font_addr, 0);
    rst = 1'b0;
    reset_logs();

    font_mode = 0;
    start_pass(sc);
    chk("busy_after_start", tw.busy, 1);
    wait_done("p1_done");
    chk("p1_wr_count",      wn, 1024 + CLR_N);
    chk("p1_done_latency",  done_cyc - sc, 1157 + CLR_N);
    chk("p1_done_after_wr", done_cyc, last_wr_cyc + 1);
    chk("p1_clear_seq",     clr_bad, 0);
    chk("p1_pattern",       pat81_bad(), 0);
    chk("p1_addr_c1r3k0",   log_addr[560], 1552);
    chk("p1_font_c1r3",     log_fa[560], 11'h421);
    chk("p1_first_addr",    log_addr[0], 0);
    chk("p1_last_addr",     log_addr[1023], 15903);
    chk("p1_untouched_y32", mem[32 * 512], UNTOUCHED);
    chk("p1_untouched_x40", mem[40], UNTOUCHED);
    step();
    chk("p1_busy_idle",  tw.busy, 0);
    chk("p1_wr_en_idle", tw.wr_en, 0);
    chk("p1_done_once",  dcount, 1);

`ifndef RESULT_TEXT_WRITER_CLEAR_EN
    font_mode = 1;
    reset_logs();
    start_pass(sc);
    wait_done("vrep_done");
    chk("vrep_wr_count", wn, 1024);
    chk("vrep_rows01_fg", rows_bad(0, 1, 2'b10), 0);
    chk("vrep_rows23_bg", rows_bad(2, 3, 2'b00), 0);
    chk("vrep_rest_bg",   rows_bad(4, 31, 2'b00), 0);

    font_mode = 0;
    reset_logs();
    start_pass(sc);
    repeat (100) step();
    tw.start = 1'b1;
    step();
    tw.start = 1'b0;
    wait_done("busy_start_done");
    repeat (20) step();
    chk("busy_start_count", wn, 1024);
    chk("busy_start_dones", dcount, 1);
    chk("busy_start_idle",  tw.busy, 0);
    chk("busy_start_latency", done_cyc - sc, 1157);
`endif

    reset_logs();
    start_pass(sc);
    repeat (300) step();
    rst = 1'b1;
    step();
    chk("midrst_wr_en", tw.wr_en, 0);
    chk("midrst_busy",  tw.busy, 0);
    chk("midrst_done",  tw.done, 0);
    rst = 1'b0;
    repeat (5) step();
    chk("midrst_no_done", dcount, 0);
    reset_logs();
    start_pass(sc);
    wait_done("rerun_done");
    chk("rerun_wr_count", wn, 1024 + CLR_N);
    chk("rerun_pattern",  pat81_bad(), 0);
    chk("rerun_first",    log_addr[0], 0);
    chk("rerun_clear",    clr_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
